pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
Central sequencer for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB). Drives per-stage latch enables and flushes from load-use hazards, taken branches resolved in MEM, and HALT decoded in ID. Runs either continuously or one cycle per step request (debug single-step). Drains the pipeline after HALT and reports an advanced-cycle count.

Parameters:
REG_ADDR_BITS, 5, register-file address width
DRAIN_CYCLES, 3, cycles after HALT acceptance before HALTED (empties ID/EX, EX/MEM, MEM/WB)
CNT_WIDTH, 32, width of cycle_count

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; leaves IDLE
run_mode  in  1  1 = continuous, 0 = single-step
step_req  in  1  step request level; rising edge = one step
id_rs  in  REG_ADDR_BITS  rs address of instruction in ID
id_rt  in  REG_ADDR_BITS  rt address of instruction in ID
id_uses_rt  in  1  ID instruction reads rt
id_halt  in  1  HALT opcode decoded in ID
ex_mem_read  in  1  instruction in EX is a load
ex_reg_w  in  REG_ADDR_BITS  destination register of instruction in EX
mem_branch_taken  in  1  branch in MEM resolved taken (zero flag)
pc_en  out  1  PC update enable
if_id_en  out  1  IF/ID latch enable
id_ex_en  out  1  ID/EX latch enable
ex_mem_en  out  1  EX/MEM latch enable
mem_wb_en  out  1  MEM/WB latch enable
if_id_flush  out  1  IF/ID loads bubble
id_ex_flush  out  1  ID/EX loads bubble
ex_mem_flush  out  1  EX/MEM loads bubble
halted  out  1  pipeline drained and stopped
state_out  out  3  current state encoding
cycle_count  out  CNT_WIDTH  number of advance cycles since reset

Behaviour:
- States: IDLE=0, RUN=1, DRAIN=2, HALTED=3. rst -> IDLE, drain counter 0, cycle_count 0, step edge register 0; all outputs 0, state_out 0.
- IDLE: all enables 0. start=1 -> RUN next cycle.
- advance (combinational) = (state in {RUN, DRAIN}) and (run_mode or step_edge); step_edge = step_req and not step_req_q. Holding step_req high yields exactly one step.
- advance=0: all enables and flushes 0; state, drain counter and cycle_count unchanged.
- advance=1 in RUN, priority high to low:
  1. mem_branch_taken: all enables 1; if_id_flush, id_ex_flush, ex_mem_flush = 1. Load-use and id_halt ignored (wrong path). Stay RUN.
  2. load_use = ex_mem_read and ex_reg_w != 0 and (ex_reg_w == id_rs or (id_uses_rt and ex_reg_w == id_rt)): pc_en=0, if_id_en=0, id_ex_flush=1; ID/EX, EX/MEM, MEM/WB enables 1. id_halt ignored this cycle (instruction re-evaluated next advance).
  3. id_halt: pc_en=0, if_id_en=1 with if_id_flush=1; downstream enables 1; HALT is not forwarded, so id_ex_flush=1. Drain counter <= DRAIN_CYCLES-1; next state DRAIN.
  4. Otherwise: all enables 1, no flushes.
- DRAIN: pc_en=0, if_id_flush=1, id_ex_flush=1; downstream enables follow advance. Branch and load-use inputs are ignored (only bubbles remain upstream). Each advance decrements the counter. An advance with counter 0 -> HALTED.
- HALTED: all enables 0, halted=1. Sticky until rst; start ignored.
- cycle_count increments on each advance=1 cycle and wraps modulo 2^CNT_WIDTH.
- Enables and flushes are combinational from state plus inputs. State, counters and step_q are registered.
- Reset asserted mid-operation: immediate async return to IDLE, regardless of step or drain progress.

Decomposition:
- Shared package holds the state encodings (IDLE/RUN/DRAIN/HALTED) and the HALT opcode constant used by decode.
- One natural sub-module, hazard_detect: pure combinational load_use comparator.
- Edge detect, FSM and counters stay in pipeline_ctrl.

Test Plan:
- Reset, then start with run_mode=1 and no hazards -> state_out 1; all enables 1; cycle_count = 10 after 10 cycles.
- ex_mem_read=1, ex_reg_w=5, id_rs=5 -> that cycle pc_en=0, if_id_en=0, id_ex_flush=1. With ex_reg_w=0 -> no stall.
- mem_branch_taken=1 and load_use true in the same cycle, with id_halt=1 -> three flushes=1, pc_en=1, state stays RUN.
- id_halt=1 in RUN, DRAIN_CYCLES=3 -> DRAIN for exactly 3 advance cycles, then halted=1; cycle_count stops incrementing.
- run_mode=0, step_req held high 5 cycles, then low 2 cycles, then high -> exactly 2 advances; cycle_count +2.
- Assert rst during DRAIN with counter 1 -> outputs 0 asynchronously, state_out 0, cycle_count 0; start then resumes RUN.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the 5-stage pipeline sequencer: FSM state encodings
// and the HALT opcode used by the ID-stage decoder.
package pipeline_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    DRAIN  = 3'd2,
    HALTED = 3'd3
  } state_t;

  localparam logic [5:0] HALT_OPCODE = 6'b111111;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs from the datapath and per-stage latch enables/flushes back to it.
// master = sequencer side, slave = datapath side.
interface pipeline_ctrl_if #(
  parameter int REG_ADDR_BITS = 5
);
  logic [REG_ADDR_BITS-1:0] id_rs;
  logic [REG_ADDR_BITS-1:0] id_rt;
  logic                     id_uses_rt;
  logic                     id_halt;
  logic                     ex_mem_read;
  logic [REG_ADDR_BITS-1:0] ex_reg_w;
  logic                     mem_branch_taken;

  logic pc_en;
  logic if_id_en;
  logic id_ex_en;
  logic ex_mem_en;
  logic mem_wb_en;
  logic if_id_flush;
  logic id_ex_flush;
  logic ex_mem_flush;

  modport master (
    input  id_rs, id_rt, id_uses_rt, id_halt, ex_mem_read, ex_reg_w, mem_branch_taken,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush
  );

  modport slave (
    output id_rs, id_rt, id_uses_rt, id_halt, ex_mem_read, ex_reg_w, mem_branch_taken,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush
  );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX writing a register the ID instruction reads.
// Register 0 is hardwired, so a load targeting it never creates a hazard.
module pipeline_ctrl_hazard_detect #(
  parameter int REG_ADDR_BITS = 5
) (
  input  logic                     ex_mem_read,
  input  logic [REG_ADDR_BITS-1:0] ex_reg_w,
  input  logic [REG_ADDR_BITS-1:0] id_rs,
  input  logic [REG_ADDR_BITS-1:0] id_rt,
  input  logic                     id_uses_rt,
  output logic                     load_use
);

  always_comb begin
    load_use = ex_mem_read && (ex_reg_w != '0) &&
               ((ex_reg_w == id_rs) || (id_uses_rt && (ex_reg_w == id_rt)));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central sequencer for the 5-stage pipeline: latch enables/flushes, HALT drain,
// continuous or single-step operation, and advanced-cycle counting.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_BITS = 5,
  parameter int DRAIN_CYCLES  = 3,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 run_mode,
  input  logic                 step_req,
  pipeline_ctrl_if.master      bus,
  output logic                 halted,
  output logic [2:0]           state_out,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t        state;
  logic [DW-1:0] drain_cnt;
  logic          step_q;
  logic          step_edge;
  logic          advance;
  logic          load_use;
  logic          halt_accept;
  logic [7:0]    ctl;

  pipeline_ctrl_hazard_detect #(
    .REG_ADDR_BITS(REG_ADDR_BITS)
  ) u_hazard (
    .ex_mem_read(bus.ex_mem_read),
    .ex_reg_w   (bus.ex_reg_w),
    .id_rs      (bus.id_rs),
    .id_rt      (bus.id_rt),
    .id_uses_rt (bus.id_uses_rt),
    .load_use   (load_use)
  );

  // ctl = {pc, if_id, id_ex, ex_mem, mem_wb enables, if_id, id_ex, ex_mem flushes}
  always_comb begin
    step_edge   = step_req && !step_q;
    advance     = ((state == RUN) || (state == DRAIN)) && (run_mode || step_edge);
    halt_accept = !bus.mem_branch_taken && !load_use && bus.id_halt;
    ctl         = '0;
    if (advance) begin
      unique case (state)
        RUN: begin
          if (bus.mem_branch_taken) ctl = 8'b11111_111;
          else if (load_use)        ctl = 8'b00111_010;
          else if (bus.id_halt)     ctl = 8'b01111_110;
          else                      ctl = 8'b11111_000;
        end
        DRAIN:   ctl = 8'b01111_110;
        default: ctl = '0;
      endcase
    end
  end

  always_comb begin
    bus.pc_en        = ctl[7];
    bus.if_id_en     = ctl[6];
    bus.id_ex_en     = ctl[5];
    bus.ex_mem_en    = ctl[4];
    bus.mem_wb_en    = ctl[3];
    bus.if_id_flush  = ctl[2];
    bus.id_ex_flush  = ctl[1];
    bus.ex_mem_flush = ctl[0];
    halted           = (state == HALTED);
    state_out        = state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      drain_cnt   <= '0;
      step_q      <= 1'b0;
      cycle_count <= '0;
    end else begin
      step_q <= step_req;
      if (advance) cycle_count <= cycle_count + CNT_WIDTH'(1);
      unique case (state)
        IDLE: if (start) state <= RUN;
        RUN: begin
          if (advance && halt_accept) begin
            state     <= DRAIN;
            drain_cnt <= DW'(DRAIN_CYCLES - 1);
          end
        end
        DRAIN: begin
          // Counter reaching zero still needs one more advance to empty MEM/WB.
          if (advance) begin
            if (drain_cnt == '0) state <= HALTED;
            else                 drain_cnt <= drain_cnt - DW'(1);
          end
        end
        HALTED:  state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: driver pushes model expectations,
// a negedge monitor pops and compares against the DUT.
module tb_pipeline_ctrl;

  localparam int RAB = 5;
  localparam int DC  = 3;
  localparam int CW  = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          run_mode;
  logic          step_req;
  logic          halted;
  logic [2:0]    state_out;
  logic [CW-1:0] cycle_count;

  pipeline_ctrl_if #(.REG_ADDR_BITS(RAB)) bus ();

  pipeline_ctrl #(
    .REG_ADDR_BITS(RAB),
    .DRAIN_CYCLES (DC),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .run_mode   (run_mode),
    .step_req   (step_req),
    .bus        (bus),
    .halted     (halted),
    .state_out  (state_out),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic start, run_mode, step_req, uses_rt, halt, mem_read, br;
    logic [RAB-1:0] rs, rt, rw;
  } stim_t;

  typedef struct {
    logic [7:0]    ctl;
    logic          halted;
    logic [2:0]    st;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model: phase flags plus remaining drain steps
  bit            m_run, m_drain, m_halt, m_prev;
  int            m_left;
  logic [CW-1:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] dut_ctl();
    return {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
            bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush};
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("enables_flushes", {24'd0, dut_ctl()}, {24'd0, e.ctl});
      chk("halted", {31'd0, halted}, {31'd0, e.halted});
      chk("state_out", {29'd0, state_out}, {29'd0, e.st});
      chk("cycle_count", cycle_count, e.cnt);
    end
  end

  function automatic void model_reset();
    m_run = 0; m_drain = 0; m_halt = 0; m_prev = 0; m_left = 0; m_cnt = '0;
  endfunction

  function automatic stim_t idle_stim(input logic rm);
    stim_t s;
    s.start = 0; s.run_mode = rm; s.step_req = 0; s.uses_rt = 0; s.halt = 0;
    s.mem_read = 0; s.br = 0; s.rs = '0; s.rt = '0; s.rw = '0;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.start    = ($urandom_range(0, 3) == 0);
    s.run_mode = ($urandom_range(0, 3) != 0);
    s.step_req = $urandom_range(0, 1) == 1;
    s.uses_rt  = $urandom_range(0, 1) == 1;
    s.halt     = ($urandom_range(0, 19) == 0);
    s.mem_read = $urandom_range(0, 1) == 1;
    s.br       = ($urandom_range(0, 9) == 0);
    s.rs       = RAB'($urandom_range(0, 3));
    s.rt       = RAB'($urandom_range(0, 3));
    s.rw       = RAB'($urandom_range(0, 3));
    return s;
  endfunction

  task automatic cycle(input stim_t s);
    exp_t e;
    bit   adv, lu;
    start            = s.start;
    run_mode         = s.run_mode;
    step_req         = s.step_req;
    bus.id_rs        = s.rs;
    bus.id_rt        = s.rt;
    bus.id_uses_rt   = s.uses_rt;
    bus.id_halt      = s.halt;
    bus.ex_mem_read  = s.mem_read;
    bus.ex_reg_w     = s.rw;
    bus.mem_branch_taken = s.br;

    adv = (m_run || m_drain) && (s.run_mode || (s.step_req && !m_prev));
    lu  = s.mem_read && (s.rw != 0) && ((s.rw == s.rs) || (s.uses_rt && (s.rw == s.rt)));
    e.ctl = 8'h00;
    if (adv) begin
      if (m_drain)     e.ctl = 8'b01111_110;
      else if (s.br)   e.ctl = 8'b11111_111;
      else if (lu)     e.ctl = 8'b00111_010;
      else if (s.halt) e.ctl = 8'b01111_110;
      else             e.ctl = 8'b11111_000;
    end
    e.halted = m_halt;
    e.st     = m_halt ? 3'd3 : m_drain ? 3'd2 : m_run ? 3'd1 : 3'd0;
    e.cnt    = m_cnt;
    q.push_back(e);

    m_prev = s.step_req;
    if (adv) m_cnt = m_cnt + 1;
    if (!m_run && !m_drain && !m_halt) begin
      if (s.start) m_run = 1;
    end else if (m_run && adv && !s.br && !lu && s.halt) begin
      m_run = 0; m_drain = 1; m_left = DC;
    end else if (m_drain && adv) begin
      m_left--;
      if (m_left == 0) begin m_drain = 0; m_halt = 1; end
    end
    @(posedge clk); #1;
  endtask

  task automatic push_zero();
    exp_t e;
    e.ctl = 8'h00; e.halted = 0; e.st = 3'd0; e.cnt = '0;
    q.push_back(e);
  endtask

  // Reset asserted away from any clock edge; effect must be visible at once.
  task automatic reset_seq();
    rst = 1'b1;
    #1;
    chk("async_state", {29'd0, state_out}, 32'd0);
    chk("async_count", cycle_count, 32'd0);
    chk("async_ctl", {24'd0, dut_ctl()}, 32'd0);
    model_reset();
    push_zero();
    @(posedge clk); #1;
    push_zero();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    stim_t s;
    rst = 1'b1; start = 0; run_mode = 0; step_req = 0;
    bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rt = 0; bus.id_halt = 0;
    bus.ex_mem_read = 0; bus.ex_reg_w = '0; bus.mem_branch_taken = 0;
    model_reset();
    @(posedge clk); #1;
    reset_seq();

    s = idle_stim(1); s.start = 1; cycle(s);
    for (int i = 0; i < 10; i++) cycle(idle_stim(1));

    s = idle_stim(1); s.mem_read = 1; s.rw = 5; s.rs = 5; cycle(s);
    s.rw = 0; s.rs = 0; cycle(s);
    s = idle_stim(1); s.mem_read = 1; s.rw = 7; s.rt = 7; s.uses_rt = 1; cycle(s);
    s.uses_rt = 0; cycle(s);

    s = idle_stim(1); s.br = 1; s.mem_read = 1; s.rw = 3; s.rs = 3; s.halt = 1; cycle(s);
    cycle(idle_stim(1));

    s = idle_stim(0);
    for (int i = 0; i < 5; i++) begin s.step_req = 1; cycle(s); end
    for (int i = 0; i < 2; i++) begin s.step_req = 0; cycle(s); end
    s.step_req = 1; cycle(s);
    s.step_req = 0; cycle(s);

    s = idle_stim(1); s.halt = 1; cycle(s);
    for (int i = 0; i < 6; i++) begin
      s = idle_stim(1); s.start = (i == 4); s.br = (i == 1); cycle(s);
    end

    reset_seq();
    s = idle_stim(1); s.start = 1; cycle(s);
    cycle(idle_stim(1));
    s = idle_stim(1); s.halt = 1; cycle(s);
    cycle(idle_stim(1));
    reset_seq();
    s = idle_stim(1); s.start = 1; cycle(s);
    for (int i = 0; i < 3; i++) cycle(idle_stim(1));

    for (int i = 0; i < 2000; i++) begin
      if (m_halt && ($urandom_range(0, 3) == 0)) reset_seq();
      else cycle(rand_stim());
    end

    cycle(idle_stim(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
